// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg
//   Shared definitions for the sequential RV32/RV64 integer ALU:
//   funct3/funct7 operation codes for the base and M-extension ops,
//   the handshake FSM state type and small decode helpers used by both
//   the top level and the iterative mul/div datapath.
package riscv_alu_pkg;

  // Base integer ops (OP / OP-IMM funct3).
  localparam logic [2:0] ADD_SUB = 3'd0;
  localparam logic [2:0] SLL     = 3'd1;
  localparam logic [2:0] SLT     = 3'd2;
  localparam logic [2:0] SLTU    = 3'd3;
  localparam logic [2:0] XOR     = 3'd4;
  localparam logic [2:0] SRL_SRA = 3'd5;
  localparam logic [2:0] OR      = 3'd6;
  localparam logic [2:0] AND     = 3'd7;

  // M-extension ops (OP funct3 with funct7 = F7_MULDIV).
  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // DIV/DIVU/REM/REMU all have funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient.
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] && f3[1];
  endfunction

  // DIV and REM treat both operands as signed.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] && !f3[0];
  endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// riscv_muldiv_iter
//   Iterative multiply/divide datapath. Works on operand magnitudes,
//   retiring BITS_PER_CYCLE bits per clock over XLEN/BITS_PER_CYCLE
//   iterations, and applies the sign fixup in the final iteration.
//   Ports:
//     clock, reset    clock and asynchronous active-low reset
//     start_i         load operands and begin (ignored while flush_i)
//     flush_i         abandon the in-flight operation
//     funct3_i        M-extension op code, sampled at start_i
//     a_i, b_i        operands (rs1, rs2), sampled at start_i
//     busy_o          an operation is iterating
//     done_o          this cycle is the final iteration; result_o is valid
//     result_o        final, sign-corrected result (valid with done_o)
//   Divide-by-zero and signed overflow are resolved outside this block.
module riscv_muldiv_iter
  import riscv_alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS) + 1;

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q;
  logic              sel_hi_q;   // mul: take upper half; div: take remainder
  logic              neg_q;      // negate the magnitude result at the end
  logic [XLEN-1:0]   opnd_q;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;      // {partial product | remainder, multiplier | quotient}

  // Operand decode at start.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (funct3_i == MULH) || (funct3_i == MULHSU) || is_signed_div(funct3_i);
    b_signed = (funct3_i == MULH) || is_signed_div(funct3_i);
    a_neg    = a_signed && a_i[XLEN-1];
    b_neg    = b_signed && b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
  end

  // One clock's worth of iterations. The extra top bit holds the add
  // carry (multiply) or the shifted-out remainder bit (divide).
  logic [2*XLEN:0] step;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value
    // on every path (here, up front); otherwise synthesis infers a latch.
    step = {1'b0, acc_q};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div_q) begin
        step = {step[2*XLEN-1:0], 1'b0};
        if (step[2*XLEN:XLEN] >= {1'b0, opnd_q}) begin
          step[2*XLEN:XLEN] = step[2*XLEN:XLEN] - {1'b0, opnd_q};
          step[0]           = 1'b1;
        end
      end else begin
        if (step[0]) begin
          step[2*XLEN:XLEN] = step[2*XLEN:XLEN] + {1'b0, opnd_q};
        end
        step = step >> 1;
      end
    end
  end

  // Sign fixup on the final iteration's value. Multiply negates the full
  // 2*XLEN product before picking a half; divide negates the picked half.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   part;

  always_comb begin
    prod = neg_q ? -step[2*XLEN-1:0] : step[2*XLEN-1:0];
    part = sel_hi_q ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    if (is_div_q) begin
      result_o = neg_q ? -part : part;
    end else begin
      result_o = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(ITERS - 1));
  assign busy_o = busy_q;

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking (=) here would create ordering races.
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      is_div_q <= is_div_op(funct3_i);
      if (is_div_op(funct3_i)) begin
        sel_hi_q <= is_rem_op(funct3_i);
        // Remainder follows the dividend; quotient is s1 ^ s2.
        neg_q    <= is_rem_op(funct3_i) ? a_neg : (a_neg ^ b_neg);
        opnd_q   <= b_mag;
        acc_q    <= {{XLEN{1'b0}}, a_mag};
      end else begin
        sel_hi_q <= (funct3_i != MUL);
        neg_q    <= a_neg ^ b_neg;
        opnd_q   <= a_mag;
        acc_q    <= {{XLEN{1'b0}}, b_mag};
      end
    end else if (busy_q) begin
      acc_q <= step[2*XLEN-1:0];
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_alu_seq.sv
// riscv_alu_seq
//   Execute-stage integer ALU with valid/ready handshakes. Base RV32I/RV64I
//   ALU ops complete in one cycle; M-extension multiply/divide run on the
//   iterative riscv_muldiv_iter datapath.
//   Ports:
//     clock, reset                 clock and asynchronous active-low reset
//     in_valid / in_ready          operation handshake
//     is_op_alu, is_op_alu_imm     OP / OP-IMM opcode select
//     op_funct3, op_funct7         operation code (funct7 = imm[11:5] for OP-IMM)
//     reg_s1, reg_s2, imm          operands
//     flush                        drop in-flight operation and held result
//     out_valid / out_ready        result handshake
//     rd_alu                       result, held stable while out_valid && !out_ready
//     busy                         iterative mul/div in progress
//   XLEN must be 32 or 64; BITS_PER_CYCLE must be 1, 2 or 4.
module riscv_alu_seq
  import riscv_alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_op_alu,
  input  logic            is_op_alu_imm,
  input  logic [2:0]      op_funct3,
  input  logic [6:0]      op_funct7,
  input  logic [XLEN-1:0] reg_s1,
  input  logic [XLEN-1:0] reg_s2,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_alu,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [XLEN-1:0] rd_q;
  logic [XLEN-1:0] rd_d;

  logic            accept;
  logic [XLEN-1:0] op2;
  logic            is_m;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0] base_res;
  logic            div_zero, div_ovf, div_special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] fast_res;
  logic            mdu_start, mdu_done, mdu_busy;
  logic [XLEN-1:0] mdu_result;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  assign op2   = is_op_alu_imm ? imm : reg_s2;
  assign shamt = op2[SHAMT_W-1:0];
  // OP-IMM never encodes M, whatever imm[11:5] happens to hold.
  assign is_m  = is_op_alu && !is_op_alu_imm && (op_funct7 == F7_MULDIV);

  // Single-cycle base ALU.
  always_comb begin
    base_res = '0;
    case (op_funct3)
      ADD_SUB: base_res = (is_op_alu && !is_op_alu_imm && op_funct7[5])
                          ? reg_s1 - op2 : reg_s1 + op2;
      SLL:     base_res = reg_s1 << shamt;
      SLT:     base_res = {{(XLEN-1){1'b0}}, ($signed(reg_s1) < $signed(op2))};
      // SLTIU compares the already sign-extended immediate as unsigned.
      SLTU:    base_res = {{(XLEN-1){1'b0}}, (reg_s1 < op2)};
      XOR:     base_res = reg_s1 ^ op2;
      SRL_SRA: base_res = op_funct7[5] ? XLEN'($signed(reg_s1) >>> shamt)
                                       : reg_s1 >> shamt;
      OR:      base_res = reg_s1 | op2;
      AND:     base_res = reg_s1 & op2;
      default: base_res = '0;
    endcase
  end

  // Division corner cases bypass the iterative unit and finish in one cycle.
  assign div_zero    = (op2 == '0);
  assign div_ovf     = is_signed_div(op_funct3) && (reg_s1 == XLEN_MIN) && (op2 == '1);
  assign div_special = is_m && is_div_op(op_funct3) && (div_zero || div_ovf);

  always_comb begin
    if (div_zero) begin
      special_res = is_rem_op(op_funct3) ? reg_s1 : '1;
    end else begin
      special_res = is_rem_op(op_funct3) ? '0 : XLEN_MIN;
    end
  end

  always_comb begin
    fast_res = '0;
    if (is_m) begin
      fast_res = special_res;
    end else if (is_op_alu || is_op_alu_imm) begin
      fast_res = base_res;
    end
  end

  assign mdu_start = accept && is_m && !div_special;

  // Result register loads from the iterative unit when it finishes,
  // otherwise from the single-cycle path at accept.
  assign rd_d = (state_q == BUSY) ? mdu_result : fast_res;

  riscv_muldiv_iter #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_muldiv (
    .clock    (clock),
    .reset    (reset),
    .start_i  (mdu_start),
    .flush_i  (flush),
    .funct3_i (op_funct3),
    .a_i      (reg_s1),
    .b_i      (op2),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done),
    .result_o (mdu_result)
  );

  // Handshake FSM. flush outranks everything but reset; an accept can only
  // occur in IDLE or DONE (in_ready is low in BUSY).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_q        <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      if (mdu_start) begin
        state_q     <= BUSY;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        busy_q      <= 1'b0;
        rd_q        <= rd_d;
      end
    end else begin
      case (state_q)
        BUSY: begin
          if (mdu_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_q        <= rd_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rd_alu    = rd_q;

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Self-checking bench for riscv_alu_seq: directed vector table, hand-written
// handshake/flush/reset sequences and randomized ops against a reference
// model built on plain integer arithmetic. A second instance with
// BITS_PER_CYCLE=4 covers the faster iteration rate.
module tb_riscv_alu_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, is_op_alu, is_op_alu_imm, flush, out_ready, sel4;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] s1, s2, imm;

  logic        in_valid1, in_ready1, out_valid1, busy1;
  logic        in_valid4, in_ready4, out_valid4, busy4;
  logic [31:0] rd1, rd4;
  logic        in_ready, out_valid, busy;
  logic [31:0] rd_alu;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign in_valid1 = in_valid && !sel4;
  assign in_valid4 = in_valid && sel4;
  assign in_ready  = sel4 ? in_ready4  : in_ready1;
  assign out_valid = sel4 ? out_valid4 : out_valid1;
  assign busy      = sel4 ? busy4      : busy1;
  assign rd_alu    = sel4 ? rd4        : rd1;

  riscv_alu_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .is_op_alu(is_op_alu), .is_op_alu_imm(is_op_alu_imm),
    .op_funct3(f3), .op_funct7(f7), .reg_s1(s1), .reg_s2(s2), .imm(imm),
    .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .rd_alu(rd1), .busy(busy1)
  );

  riscv_alu_seq #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .is_op_alu(is_op_alu), .is_op_alu_imm(is_op_alu_imm),
    .op_funct3(f3), .op_funct7(f7), .reg_s1(s1), .reg_s2(s2), .imm(imm),
    .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
    .rd_alu(rd4), .busy(busy4)
  );

  typedef struct {
    string       name;
    logic        a;
    logic        i;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] im;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ISA semantics via native integer arithmetic.
  function automatic logic [31:0] ref_result(input logic a, input logic i,
      input logic [2:0] fn3, input logic [6:0] fn7,
      input logic [31:0] x, input logic [31:0] y, input logic [31:0] im);
    logic [31:0] op2;
    longint      xs, ys, yu, p;
    logic [63:0] pu;
    int          xi, yi;
    logic [4:0]  sh;
    op2 = i ? im : y;
    sh  = op2[4:0];
    if (!a && !i) return 32'h0;
    if (a && !i && fn7 == 7'h01) begin
      xs = $signed(x); ys = $signed(y); yu = {32'h0, y};
      xi = x; yi = y;
      case (fn3)
        3'd0: begin p = xs * ys; return p[31:0]; end
        3'd1: begin p = xs * ys; return p[63:32]; end
        3'd2: begin p = xs * yu; return p[63:32]; end
        3'd3: begin pu = {32'h0, x} * {32'h0, y}; return pu[63:32]; end
        3'd4: begin
          if (y == 0) return 32'hFFFFFFFF;
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
          return xi / yi;
        end
        3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
        3'd6: begin
          if (y == 0) return x;
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
          return xi % yi;
        end
        default: return (y == 0) ? x : x % y;
      endcase
    end
    case (fn3)
      3'd0: return (a && !i && fn7[5]) ? x - op2 : x + op2;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(op2)) ? 32'd1 : 32'd0;
      3'd3: return (x < op2) ? 32'd1 : 32'd0;
      3'd4: return x ^ op2;
      3'd5: return fn7[5] ? 32'($signed(x) >>> sh) : x >> sh;
      3'd6: return x | op2;
      default: return x & op2;
    endcase
  endfunction

  // Expected accept-to-valid latency: iterative M ops take iters+1.
  function automatic int ref_lat(input logic a, input logic i, input logic [2:0] fn3,
      input logic [6:0] fn7, input logic [31:0] x, input logic [31:0] y, input int iters);
    if (!(a && !i && fn7 == 7'h01)) return 1;
    if (fn3[2] && (y == 0 || (!fn3[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
    return iters + 1;
  endfunction

  function automatic vec_t mk(input string n, input logic a, input logic i,
      input logic [2:0] fn3, input logic [6:0] fn7, input logic [31:0] x,
      input logic [31:0] y, input logic [31:0] im, input logic [31:0] e, input int l);
    vec_t v;
    v.name = n; v.a = a; v.i = i; v.f3 = fn3; v.f7 = fn7;
    v.s1 = x; v.s2 = y; v.im = im; v.exp = e; v.lat = l;
    return v;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic a, input logic i, input logic [2:0] fn3,
      input logic [6:0] fn7, input logic [31:0] x, input logic [31:0] y, input logic [31:0] im);
    is_op_alu = a; is_op_alu_imm = i; f3 = fn3; f7 = fn7; s1 = x; s2 = y; imm = im;
  endtask

  // Present one op with out_ready=1, return result, latency and the
  // number of sampled cycles with busy=1 before the result appeared.
  task automatic run_op(input logic a, input logic i, input logic [2:0] fn3,
      input logic [6:0] fn7, input logic [31:0] x, input logic [31:0] y, input logic [31:0] im,
      output logic [31:0] res, output int lat, output int busy_cycles);
    int w;
    @(negedge clock);
    drive(a, i, fn3, fn7, x, y, im);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    busy_cycles = 0;
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 200) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      lat++;
    end
    res = rd_alu;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    int          lat, bc, w;
    logic        ok_v, ok_r, ok_d;
    logic        ra, ri;
    logic [2:0]  rf3;
    logic [6:0]  rf7;
    logic [31:0] rx, ry, rim, r12;

    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; sel4 = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);

    // Reset state, both instances.
    repeat (3) @(negedge clock);
    check("reset out_valid", out_valid1, 1'b0);
    check("reset busy", busy1, 1'b0);
    check("reset rd_alu", rd1, 32'h0);
    check("reset in_ready", in_ready1, 1'b1);
    check("reset4 out_valid", out_valid4, 1'b0);
    check("reset4 in_ready", in_ready4, 1'b1);
    reset = 1'b1;

    // Back-to-back base ops: one result per cycle.
    @(negedge clock);
    drive(1'b1, 1'b0, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0);
    in_valid = 1'b1;
    @(negedge clock);
    check("tput add valid", out_valid, 1'b1);
    check("tput add rd", rd_alu, 32'd12);
    check("tput in_ready", in_ready, 1'b1);
    drive(1'b1, 1'b0, 3'd0, 7'h20, 32'd5, 32'd7, 32'd0);
    @(negedge clock);
    check("tput sub valid", out_valid, 1'b1);
    check("tput sub rd", rd_alu, 32'hFFFFFFFE);
    in_valid = 1'b0;

    // Directed vector table.
    vecs.push_back(mk("ADD",      1, 0, 3'd0, 7'h00, 32'd5,        32'd7,        32'd0,        32'd12,       1));
    vecs.push_back(mk("SUB",      1, 0, 3'd0, 7'h20, 32'd5,        32'd7,        32'd0,        32'hFFFFFFFE, 1));
    vecs.push_back(mk("ADDI alt", 0, 1, 3'd0, 7'h20, 32'd5,        32'd0,        32'h407,      32'h40C,      1));
    vecs.push_back(mk("ADDI f7m", 0, 1, 3'd0, 7'h01, 32'd3,        32'd0,        32'h23,       32'h26,       1));
    vecs.push_back(mk("SRAI",     0, 1, 3'd5, 7'h20, 32'h80000000, 32'd0,        32'h404,      32'hF8000000, 1));
    vecs.push_back(mk("SRLI",     0, 1, 3'd5, 7'h00, 32'h80000000, 32'd0,        32'h4,        32'h08000000, 1));
    vecs.push_back(mk("SLL",      1, 0, 3'd1, 7'h00, 32'd1,        32'h25,       32'd0,        32'h20,       1));
    vecs.push_back(mk("SLT",      1, 0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd1,        1));
    vecs.push_back(mk("SLTU",     1, 0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1));
    vecs.push_back(mk("SLTIU",    0, 1, 3'd3, 7'h7F, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd1,        1));
    vecs.push_back(mk("XOR",      1, 0, 3'd4, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0FF00FF0, 1));
    vecs.push_back(mk("OR",       1, 0, 3'd6, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hFFF0FFF0, 1));
    vecs.push_back(mk("AND",      1, 0, 3'd7, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'hF000F000, 1));
    vecs.push_back(mk("NONE",     0, 0, 3'd0, 7'h00, 32'd5,        32'd7,        32'd0,        32'd0,        1));
    vecs.push_back(mk("MULH",     1, 0, 3'd1, 7'h01, 32'h80000000, 32'h80000000, 32'd0,        32'h40000000, 33));
    vecs.push_back(mk("MULHU",    1, 0, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 33));
    vecs.push_back(mk("MULHSU",   1, 0, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 33));
    vecs.push_back(mk("MUL",      1, 0, 3'd0, 7'h01, 32'd7,        32'hFFFFFFFD, 32'd0,        32'hFFFFFFEB, 33));
    vecs.push_back(mk("DIV /0",   1, 0, 3'd4, 7'h01, 32'd7,        32'd0,        32'd0,        32'hFFFFFFFF, 1));
    vecs.push_back(mk("REMU /0",  1, 0, 3'd7, 7'h01, 32'd7,        32'd0,        32'd0,        32'd7,        1));
    vecs.push_back(mk("DIV ovf",  1, 0, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1));
    vecs.push_back(mk("REM ovf",  1, 0, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,        1));
    vecs.push_back(mk("DIV -7/2", 1, 0, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd0,        32'hFFFFFFFD, 33));
    vecs.push_back(mk("REM -7/2", 1, 0, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd0,        32'hFFFFFFFF, 33));
    vecs.push_back(mk("DIV 7/-2", 1, 0, 3'd4, 7'h01, 32'd7,        32'hFFFFFFFE, 32'd0,        32'hFFFFFFFD, 33));
    vecs.push_back(mk("REM 7/-2", 1, 0, 3'd6, 7'h01, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd1,        33));
    vecs.push_back(mk("DIVU",     1, 0, 3'd5, 7'h01, 32'd100,      32'd7,        32'd0,        32'd14,       33));
    vecs.push_back(mk("REMU",     1, 0, 3'd7, 7'h01, 32'd100,      32'd7,        32'd0,        32'd2,        33));

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].i, vecs[k].f3, vecs[k].f7, vecs[k].s1, vecs[k].s2, vecs[k].im,
             res, lat, bc);
      check($sformatf("%s result", vecs[k].name), res, vecs[k].exp);
      check($sformatf("%s latency", vecs[k].name), lat, vecs[k].lat);
      check($sformatf("%s busy cycles", vecs[k].name), bc, vecs[k].lat - 1);
    end

    // Randomized ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      w = $urandom_range(0, 9);
      rx = rnd_opnd(); ry = rnd_opnd(); r12 = $urandom;
      rim = {{20{r12[11]}}, r12[11:0]};
      rf3 = 3'($urandom_range(0, 7));
      if (w <= 3) begin
        ra = 1; ri = 0; rf7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end else if (w <= 6) begin
        ra = 0; ri = 1; rf7 = rim[11:5];
      end else if (w <= 8) begin
        ra = 1; ri = 0; rf7 = 7'h01;
      end else begin
        ra = 0; ri = 0; rf7 = 7'h00;
      end
      run_op(ra, ri, rf3, rf7, rx, ry, rim, res, lat, bc);
      check($sformatf("rand%0d f3=%0d f7=%0h result", n, rf3, rf7), res,
            ref_result(ra, ri, rf3, rf7, rx, ry, rim));
      check($sformatf("rand%0d latency", n), lat, ref_lat(ra, ri, rf3, rf7, rx, ry, 32));
    end

    // Backpressure: result held stable while out_ready=0.
    @(negedge clock);
    drive(1'b1, 1'b0, 3'd5, 7'h01, 32'd100, 32'd7, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    w = 0;
    @(negedge clock);
    while (!out_valid && w < 100) begin
      @(negedge clock);
      w++;
    end
    ok_v = 1; ok_r = 1; ok_d = 1;
    drive(1'b1, 1'b0, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b1) ok_v = 0;
      if (rd_alu !== 32'd14) ok_d = 0;
      if (in_ready !== 1'b0) ok_r = 0;
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("bp out_valid held", ok_v, 1'b1);
    check("bp rd_alu stable", ok_d, 1'b1);
    check("bp in_ready low", ok_r, 1'b1);
    out_ready = 1'b1;
    @(negedge clock);
    check("bp drained", out_valid, 1'b0);

    // Flush during BUSY: op abandoned, concurrent in_valid dropped.
    drive(1'b1, 1'b0, 3'd0, 7'h01, 32'd3, 32'd5, 32'd0);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("flush pre busy", busy, 1'b1);
    flush = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0);
    in_valid = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("flush out_valid", out_valid, 1'b0);
    check("flush busy", busy, 1'b0);
    ok_v = 1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) ok_v = 0;
      @(negedge clock);
    end
    check("flush no late result", ok_v, 1'b1);

    // Flush in IDLE with in_valid: must not be accepted.
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("flush idle no accept", out_valid, 1'b0);

    // Reset mid-MUL: outputs return to reset values at once.
    run_op(1'b1, 1'b0, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, res, lat, bc);
    check("pre-reset add", res, 32'd12);
    @(negedge clock);
    drive(1'b1, 1'b0, 3'd0, 7'h01, 32'd1234, 32'd5678, 32'd0);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("mid-op busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid-op reset out_valid", out_valid, 1'b0);
    check("mid-op reset busy", busy, 1'b0);
    check("mid-op reset rd_alu", rd_alu, 32'h0);
    check("mid-op reset in_ready", in_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    ok_v = 1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) ok_v = 0;
      @(negedge clock);
    end
    check("mid-op reset no result", ok_v, 1'b1);

    // BITS_PER_CYCLE=4 instance.
    sel4 = 1'b1;
    run_op(1'b1, 1'b0, 3'd0, 7'h01, 32'd12345, 32'd6789, 32'd0, res, lat, bc);
    check("bpc4 MUL result", res, 32'd83810205);
    check("bpc4 MUL latency", lat, 9);
    for (int n = 0; n < 20; n++) begin
      rx = rnd_opnd(); ry = rnd_opnd();
      rf3 = 3'($urandom_range(0, 7));
      run_op(1'b1, 1'b0, rf3, 7'h01, rx, ry, 32'd0, res, lat, bc);
      check($sformatf("bpc4 rand%0d f3=%0d result", n, rf3), res,
            ref_result(1'b1, 1'b0, rf3, 7'h01, rx, ry, 32'd0));
      check($sformatf("bpc4 rand%0d latency", n), lat,
            ref_lat(1'b1, 1'b0, rf3, 7'h01, rx, ry, 8));
    end

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
